// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM encoding,
// the response entry layout and the divide-by-zero rule.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_ROL = 3'b111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    localparam logic [7:0] DIV_ERR_VAL = 8'hFF;

    typedef struct packed {
        logic       err;
        logic [2:0] op;
        logic [7:0] result;
    } rsp_entry_t;

    localparam int unsigned RSP_W = $bits(rsp_entry_t);

    function automatic logic is_div_err(input logic [2:0] op, input logic [3:0] b);
        return (op == OP_DIV) && (b == 4'd0);
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous response FIFO. Reads are first-word-fall-through; dout is zero
// while empty. A push while full is only honoured if a pop happens the same cycle.
module rsp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of 2)
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command/response stage in front of the combinational 4-bit ALU. Accepts a
// command in IDLE, presents registered operands for one EXEC cycle, and pushes
// the tagged result into the response FIFO at the end of that cycle.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [3:0]                   cmd_a,
    input  logic [3:0]                   cmd_b,
    input  logic [2:0]                   cmd_op,
    output logic [3:0]                   alu_a,
    output logic [3:0]                   alu_b,
    output logic [2:0]                   alu_opcode,
    input  logic [7:0]                   alu_result,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [7:0]                   rsp_result,
    output logic [2:0]                   rsp_op,
    output logic                         rsp_err,
    output logic [$clog2(FIFO_DEPTH):0]  rsp_count,
    output logic [CNT_W-1:0]             err_cnt
);

    logic [0:0] state;
    logic       accept;
    logic       exec;
    logic       err;
    logic       fifo_empty;
    logic       fifo_full;
    rsp_entry_t push_entry;
    rsp_entry_t head;

    // Space is reserved at accept time, so the EXEC push can never be refused
    assign cmd_ready = !rst && (state == ST_IDLE) && !fifo_full;
    assign accept    = cmd_valid && cmd_ready;
    assign exec      = (state == ST_EXEC);
    assign err       = is_div_err(alu_opcode, alu_b);

    // Build the entry pushed at the end of EXEC; ALU output is ignored on div-by-zero
    always_comb begin
        push_entry        = '0;
        push_entry.err    = err;
        push_entry.op     = alu_opcode;
        push_entry.result = err ? DIV_ERR_VAL : alu_result;
    end

    // Two-state FSM and operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_a      <= cmd_a;
                        alu_b      <= cmd_b;
                        alu_opcode <= cmd_op;
                        state      <= ST_EXEC;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Saturating count of div-by-zero pushes
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (exec && err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RSP_W)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (exec),
        .din   (push_entry),
        .pop   (rsp_ready),
        .dout  (head),
        .count (rsp_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rsp_valid  = !fifo_empty;
    assign rsp_result = head.result;
    assign rsp_op     = head.op;
    assign rsp_err    = head.err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer. A behavioural ALU closes the loop;
// expected responses are hand-computed constants queued at command accept and
// checked by an independent monitor whenever a response is popped.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [2:0] rsp_op;
    logic       rsp_err;
    logic [2:0] rsp_count;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] sbq[$];

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .FIFO_DEPTH (4),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .rsp_count  (rsp_count),
        .err_cnt    (err_cnt)
    );

    // Behavioural ALU; returns 0 on divide-by-zero so the DUT must substitute FF
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] op);
        logic [7:0] rot;
        rot = {a, a} << b[1:0];
        case (op)
            3'b000:  return {4'd0, a} + {4'd0, b};
            3'b001:  return {4'd0, a} - {4'd0, b};
            3'b010:  return {4'd0, a} * {4'd0, b};
            3'b011:  return (b == 4'd0) ? 8'h00 : ({4'd0, a} / {4'd0, b});
            3'b100:  return {4'd0, a & b};
            3'b101:  return {4'd0, a | b};
            3'b110:  return {4'd0, a ^ b};
            default: return {4'd0, rot[7:4]};
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_a, alu_b, alu_opcode);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every popped response against the scoreboard head
    always @(negedge clk) begin
        if (!rst) begin
            check("count_bound", 32'(rsp_count <= 3'd4), 32'd1);
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_result), 32'hDEAD);
                end else begin
                    logic [11:0] e;
                    e = sbq.pop_front();
                    check("rsp_result", 32'(rsp_result), 32'(e[7:0]));
                    check("rsp_op", 32'(rsp_op), 32'(e[10:8]));
                    check("rsp_err", 32'(rsp_err), 32'(e[11]));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [7:0] exp_res, input logic exp_err);
        int waited = 0;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_ready) begin
                sbq.push_back({exp_err, op, exp_res});
                break;
            end
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk) #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        rsp_ready = 1'b1;
        while (sbq.size() != 0 || rsp_valid) begin
            @(posedge clk) #1;
            waited++;
            if (waited > 100) break;
        end
        check("drain_done", 32'(sbq.size()), 32'd0);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic       err;
    } vec_t;

    vec_t mix[10] = '{
        '{4'd3,  4'd4,  3'b000, 8'h07, 1'b0},
        '{4'd2,  4'd5,  3'b001, 8'hFD, 1'b0},
        '{4'd7,  4'd9,  3'b010, 8'h3F, 1'b0},
        '{4'd13, 4'd4,  3'b011, 8'h03, 1'b0},
        '{4'hC,  4'hA,  3'b100, 8'h08, 1'b0},
        '{4'hC,  4'h3,  3'b101, 8'h0F, 1'b0},
        '{4'hF,  4'h5,  3'b110, 8'h0A, 1'b0},
        '{4'h9,  4'd1,  3'b111, 8'h03, 1'b0},
        '{4'd6,  4'd0,  3'b011, 8'hFF, 1'b1},
        '{4'hF,  4'hF,  3'b000, 8'h1E, 1'b0}
    };

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_count", 32'(rsp_count), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
        check("rst_rsp_data", 32'({rsp_result, rsp_op, rsp_err}), 32'd0);
        @(posedge clk) #1;
        rst = 1'b0;

        // 1. ADD with latency check: empty during EXEC, visible the cycle after
        send(4'd9, 4'd7, 3'b000, 8'h10, 1'b0);
        @(negedge clk);
        check("t1_exec_valid", 32'(rsp_valid), 32'd0);
        check("t1_exec_ready", 32'(cmd_ready), 32'd0);
        check("t1_alu_regs", 32'({alu_a, alu_b, alu_opcode}), 32'({4'd9, 4'd7, 3'b000}));
        @(negedge clk);
        check("t1_valid", 32'(rsp_valid), 32'd1);
        check("t1_head", 32'({rsp_result, rsp_op, rsp_err}), 32'({8'h10, 3'b000, 1'b0}));
        check("t1_count", 32'(rsp_count), 32'd1);
        @(posedge clk) #1;
        drain();

        // 2. Divide by zero
        send(4'd5, 4'd0, 3'b011, 8'hFF, 1'b1);
        repeat (2) @(negedge clk);
        check("t2_err_cnt", 32'(err_cnt), 32'd1);
        @(posedge clk) #1;
        drain();

        // 3. Backpressure: five MULs, only four fit
        rsp_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(4'd15, 4'd15, 3'b010, 8'hE1, 1'b0);
            end
            begin
                repeat (14) @(negedge clk);
                check("t3_count_full", 32'(rsp_count), 32'd4);
                check("t3_ready_held", 32'(cmd_ready), 32'd0);
                check("t3_head", 32'(rsp_result), 32'h0000_00E1);
                check("t3_pending", 32'(cmd_valid), 32'd1);
                @(posedge clk) #1;
                rsp_ready = 1'b1;
            end
        join
        drain();

        // 4. Refill with a simultaneous push and pop
        rsp_ready = 1'b0;
        send(4'd1, 4'd1, 3'b000, 8'h02, 1'b0);
        send(4'd2, 4'd3, 3'b010, 8'h06, 1'b0);
        send(4'd7, 4'd2, 3'b001, 8'h05, 1'b0);
        send(4'd8, 4'd2, 3'b011, 8'h04, 1'b0);
        @(posedge clk) #1;
        check("t4_full", 32'(rsp_count), 32'd4);
        rsp_ready = 1'b1;
        @(posedge clk) #1;
        rsp_ready = 1'b0;
        check("t4_after_pop", 32'(rsp_count), 32'd3);
        send(4'd1, 4'd2, 3'b000, 8'h03, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_exec_count", 32'(rsp_count), 32'd3);
        @(posedge clk) #1;
        rsp_ready = 1'b0;
        check("t4_push_pop_count", 32'(rsp_count), 32'd3);
        drain();

        // 5. Reset during EXEC discards the command and clears err_cnt
        cmd_a = 4'd3;
        cmd_b = 4'd1;
        cmd_op = 3'b001;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("t5_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk) #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk) #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_valid", 32'(rsp_valid), 32'd0);
        check("t5_count", 32'(rsp_count), 32'd0);
        check("t5_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk) #1;

        // 6. Mixed stream with wrap-around
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(mix[i].a, mix[i].b, mix[i].op, mix[i].res, mix[i].err);
        drain();
        check("t6_err_cnt", 32'(err_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
